// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed access latency.
// It accepts one request at a time and answers each accepted request with a single response pulse.
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];

  logic                w_accept;
  logic                w_commit;
  logic                w_cmt_we;
  logic [ADDR_W-1:0]   w_cmt_addr;
  logic [DATA_W-1:0]   w_cmt_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // With zero latency the commit happens on the accepting edge, so it must use the live inputs.
  always_comb begin
    w_next     = r_state;
    w_commit   = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = rst_n;
        w_accept  = req_valid && rst_n;
        if (w_accept) begin
          if (ZERO_LAT) begin
            w_commit = 1'b1;
            w_next   = RESP;
          end else begin
            w_next   = WAIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_cmt_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_cmt_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_cmt_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= CNT_INIT;
    end else if (r_state == WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Latched request copies; later changes on the request inputs are ignored.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_cmt_we) r_mem[w_cmt_addr] <= w_cmt_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
    end else if (w_commit) begin
      resp_rdata <= w_cmt_we ? w_cmt_wdata : r_mem[w_cmt_addr];
    end
  end

endmodule
